// File: rtl/if_bht_pkg.sv
// if_bht_pkg: shared definitions for the fetch-stage branch history table.
//   - BHT_XLEN   : default address width
//   - BHT_SNT/WNT/WT/ST : 2-bit saturating counter encodings
//   - bht_state_t: sweep/run state machine encoding
package if_bht_pkg;

   localparam int BHT_XLEN = 32;

   localparam logic [1:0] BHT_SNT = 2'b00;   // strongly not-taken
   localparam logic [1:0] BHT_WNT = 2'b01;   // weakly not-taken (init value)
   localparam logic [1:0] BHT_WT  = 2'b10;   // weakly taken
   localparam logic [1:0] BHT_ST  = 2'b11;   // strongly taken

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bht_state_t;

endpackage

// File: rtl/if_bht_sat_cnt.sv
// bht_sat_cnt: combinational next value of a 2-bit saturating counter.
// Ports:
//   cnt  in  [1:0]  current counter value
//   inc  in         1 = count up (taken), 0 = count down (not taken)
//   nxt  out [1:0]  updated value, saturating at BHT_ST / BHT_SNT
module bht_sat_cnt
   import if_bht_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       inc,
   output logic [1:0] nxt
);

   always_comb begin
      nxt = cnt;
      if (inc) begin
         if (cnt != BHT_ST) nxt = cnt + 2'd1;
      end else begin
         if (cnt != BHT_SNT) nxt = cnt - 2'd1;
      end
   end

endmodule

// File: rtl/if_bht.sv
// if_bht: branch history table of 2^IDX_W two-bit saturating counters.
// Predicts conditional branches at fetch and retrains from the EX-stage
// branch check. After reset a sweep writes weak-NT into every entry, one per
// cycle; then one prediction and one update are served every cycle.
//
// Optional feature: define BHT_GHR_EN for gshare indexing (PC bits XOR a
// global history register updated at branch resolution).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_valid, if_pc     fetch-side branch needing a prediction
//   pred_take, pred_idx registered prediction and table index used
//   pred_ready          high once the init sweep has finished
//   ex_branch, ex_idx   EX-side resolved branch and its carried index
//   ex_take             prediction carried with that branch
//   predict_fail        EX mispredict flag
//   br_cnt, miss_cnt    resolved-branch and mispredict statistics
module if_bht
   import if_bht_pkg::*;
#(
   parameter int XLEN  = BHT_XLEN,
   parameter int IDX_W = 6,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [XLEN-1:0]  if_pc,
   output logic             pred_take,
   output logic [IDX_W-1:0] pred_idx,
   output logic             pred_ready,
   input  logic             ex_branch,
   input  logic [IDX_W-1:0] ex_idx,
   input  logic             ex_take,
   input  logic             predict_fail,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int DEPTH = 1 << IDX_W;

   bht_state_t       state_reg, state_next;
   logic [IDX_W-1:0] sweep_ptr_reg;
   logic [1:0]       bht_mem [DEPTH];

   logic             sweep_we;
   logic             run_en;
   logic             sweep_last;
   logic             actual_take;
   logic [IDX_W-1:0] hist_hash;
   logic [IDX_W-1:0] rd_idx;
   logic [1:0]       upd_cur;
   logic [1:0]       upd_next;

   logic             pred_take_reg;
   logic [IDX_W-1:0] pred_idx_reg;
   logic             pred_ready_reg;
   logic [CNT_W-1:0] br_cnt_reg;
   logic [CNT_W-1:0] miss_cnt_reg;

   // PC bits outside the index field do not affect the prediction.
   logic unused_pc;
   assign unused_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

   // The carried prediction XOR the mispredict flag recovers the real outcome.
   assign actual_take = ex_take ^ predict_fail;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_INIT;
      else     state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   assign sweep_last = (sweep_ptr_reg == {IDX_W{1'b1}});

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_INIT: if (sweep_last) state_next = ST_RUN;
         ST_RUN:  state_next = ST_RUN;
         default: state_next = ST_INIT;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      sweep_we = 1'b0;
      run_en   = 1'b0;
      case (state_reg)
         ST_INIT: sweep_we = 1'b1;
         ST_RUN:  run_en   = 1'b1;
         default: sweep_we = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)           sweep_ptr_reg <= '0;
      else if (sweep_we) sweep_ptr_reg <= sweep_ptr_reg + 1'b1;
   end

   // ---------------- index hashing ----------------
`ifdef BHT_GHR_EN
   logic [IDX_W-1:0] ghr_reg;

   // Non-speculative history: shifted only when a branch resolves.
   always_ff @(posedge clk) begin
      if (rst)
         ghr_reg <= '0;
      else if (run_en && ex_branch)
         ghr_reg <= {ghr_reg[IDX_W-2:0], actual_take};
   end

   assign hist_hash = ghr_reg;
`else
   assign hist_hash = '0;
`endif

   assign rd_idx = if_pc[IDX_W+1:2] ^ hist_hash;

   // ---------------- counter table ----------------
   assign upd_cur = bht_mem[ex_idx];

   bht_sat_cnt u_sat_cnt (
      .cnt (upd_cur),
      .inc (actual_take),
      .nxt (upd_next)
   );

   // No reset on the array: the sweep is what initialises it. EX updates are
   // only honoured in RUN, where the sweep port is idle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (sweep_we)
            bht_mem[sweep_ptr_reg] <= BHT_WNT;
         else if (ex_branch)
            bht_mem[ex_idx] <= upd_next;
      end
   end

   // ---------------- prediction ----------------
   // The read samples the array before this edge's write lands, so a
   // same-index update is seen only by the following prediction.
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_take_reg  <= 1'b0;
         pred_idx_reg   <= '0;
         pred_ready_reg <= 1'b0;
      end else begin
         pred_ready_reg <= (state_next == ST_RUN);
         if (if_valid) begin
            pred_idx_reg  <= rd_idx;
            pred_take_reg <= run_en & bht_mem[rd_idx][1];
         end
      end
   end

   // ---------------- statistics ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_reg   <= '0;
         miss_cnt_reg <= '0;
      end else if (run_en && ex_branch) begin
         br_cnt_reg <= br_cnt_reg + 1'b1;
         if (predict_fail) miss_cnt_reg <= miss_cnt_reg + 1'b1;
      end
   end

   assign pred_take  = pred_take_reg;
   assign pred_idx   = pred_idx_reg;
   assign pred_ready = pred_ready_reg;
   assign br_cnt     = br_cnt_reg;
   assign miss_cnt   = miss_cnt_reg;

endmodule

// File: tb/tb_if_bht.sv
// tb_if_bht: directed self-checking bench for if_bht (default or BHT_GHR_EN).
`timescale 1ns/1ps
module tb_if_bht;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_take;
   logic [5:0]  pred_idx;
   logic        pred_ready;
   logic        ex_branch;
   logic [5:0]  ex_idx;
   logic        ex_take;
   logic        predict_fail;
   logic [31:0] br_cnt;
   logic [31:0] miss_cnt;

   int checks = 0;
   int errors = 0;

   logic [5:0]  exp_ghr;
   int          exp_br;
   int          exp_miss;

   always #5 clk = ~clk;

   if_bht #(.XLEN(32), .IDX_W(6), .CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .pred_take    (pred_take),
      .pred_idx     (pred_idx),
      .pred_ready   (pred_ready),
      .ex_branch    (ex_branch),
      .ex_idx       (ex_idx),
      .ex_take      (ex_take),
      .predict_fail (predict_fail),
      .br_cnt       (br_cnt),
      .miss_cnt     (miss_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bench-side history model: shift in the actual outcome of a RUN update.
   task automatic model_update(input logic take, input logic fail);
      exp_br++;
      if (fail) exp_miss++;
`ifdef BHT_GHR_EN
      exp_ghr = {exp_ghr[4:0], take ^ fail};
`endif
   endtask

   // PC in the 0x100 page whose index (under the current history) is idx.
   function automatic logic [31:0] pc_for(input logic [5:0] idx);
      return {24'h000001, idx ^ exp_ghr, 2'b00};
   endfunction

   task automatic predict(input string tag, input logic [31:0] pc, input logic exp_take);
      logic [5:0] exp_idx;
      exp_idx  = pc[7:2] ^ exp_ghr;
      if_valid = 1'b1;
      if_pc    = pc;
      step();
      if_valid = 1'b0;
      check({tag, " take"}, {31'd0, pred_take}, {31'd0, exp_take});
      check({tag, " idx"},  {26'd0, pred_idx},  {26'd0, exp_idx});
   endtask

   task automatic update(input logic [5:0] idx, input logic take, input logic fail);
      ex_branch    = 1'b1;
      ex_idx       = idx;
      ex_take      = take;
      predict_fail = fail;
      step();
      ex_branch    = 1'b0;
      model_update(take, fail);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_ghr  = '0;
      exp_br   = 0;
      exp_miss = 0;
   endtask

   initial begin
      rst = 1'b1; if_valid = 0; if_pc = '0;
      ex_branch = 0; ex_idx = '0; ex_take = 0; predict_fail = 0;
      exp_ghr = '0; exp_br = 0; exp_miss = 0;
      step();
      do_reset();

      // Reset state
      check("rst pred_ready", {31'd0, pred_ready}, 32'd0);
      check("rst pred_take",  {31'd0, pred_take},  32'd0);
      check("rst pred_idx",   {26'd0, pred_idx},   32'd0);
      check("rst br_cnt",     br_cnt,   32'd0);
      check("rst miss_cnt",   miss_cnt, 32'd0);

      // Init sweep: 64 cycles not ready, predictions forced to 0
      for (int i = 0; i < 64; i++) begin
         check($sformatf("init ready c%0d", i), {31'd0, pred_ready}, 32'd0);
         if_valid = 1'b1;
         if_pc    = 32'(i * 4);
         step();
         check($sformatf("init take c%0d", i), {31'd0, pred_take}, 32'd0);
      end
      if_valid = 1'b0;
      check("init done ready", {31'd0, pred_ready}, 32'd1);

      // Every entry holds weak-NT after the sweep
      for (int i = 0; i < 64; i++)
         predict($sformatf("swept pc 0x%0h", i * 4), 32'(i * 4), 1'b0);

      // Train taken on idx 0 (PC 0x100): 01 -> 10 -> 11 -> 11
      for (int i = 0; i < 3; i++) begin
         update(6'd0, 1'b0, 1'b1);
         predict($sformatf("train T%0d", i), pc_for(6'd0), 1'b1);
      end
      // Saturate, then hysteresis: 11 -> 10 (still T) -> 01 (NT)
      for (int i = 0; i < 5; i++) update(6'd0, 1'b0, 1'b1);
      update(6'd0, 1'b1, 1'b1);
      predict("hyst NT1", pc_for(6'd0), 1'b1);
      update(6'd0, 1'b1, 1'b1);
      predict("hyst NT2", pc_for(6'd0), 1'b0);
      // Bottom saturation: 01 -> 00 -> 00 -> 00, then T -> 01 (NT), T -> 10
      for (int i = 0; i < 3; i++) update(6'd0, 1'b0, 1'b0);
      update(6'd0, 1'b1, 1'b0);
      predict("sat low T1", pc_for(6'd0), 1'b0);
      update(6'd0, 1'b1, 1'b0);
      predict("sat low T2", pc_for(6'd0), 1'b1);

      // Collision: read and update idx 5 (counter 01, actual taken) together
      if_valid     = 1'b1;
      if_pc        = pc_for(6'd5);
      ex_branch    = 1'b1;
      ex_idx       = 6'd5;
      ex_take      = 1'b0;
      predict_fail = 1'b1;
      step();
      if_valid  = 1'b0;
      ex_branch = 1'b0;
      check("collide read-first", {31'd0, pred_take}, 32'd0);
      model_update(1'b0, 1'b1);
      predict("collide next", pc_for(6'd5), 1'b1);

      check("stats br_cnt",   br_cnt,   32'(exp_br));
      check("stats miss_cnt", miss_cnt, 32'(exp_miss));

      // Reset mid-init at sweep cycle 20; updates during INIT dropped
      do_reset();
      for (int i = 0; i < 20; i++) step();
      do_reset();
      for (int i = 0; i < 64; i++) begin
         check($sformatf("reinit ready c%0d", i), {31'd0, pred_ready}, 32'd0);
         ex_branch    = (i >= 40);
         ex_idx       = 6'd7;
         ex_take      = 1'b0;
         predict_fail = 1'b1;
         step();
      end
      ex_branch = 1'b0;
      check("reinit ready", {31'd0, pred_ready}, 32'd1);
      check("reinit br_cnt",   br_cnt,   32'd0);
      check("reinit miss_cnt", miss_cnt, 32'd0);
      predict("reinit idx7 dropped", pc_for(6'd7), 1'b0);

      // History: resolve T, T, NT with two mispredicts
      update(6'd9,  1'b0, 1'b1);
      update(6'd10, 1'b1, 1'b0);
      update(6'd11, 1'b1, 1'b1);
      check("hist br_cnt",   br_cnt,   32'd3);
      check("hist miss_cnt", miss_cnt, 32'd2);
      if_valid = 1'b1;
      if_pc    = 32'h40;
      step();
      if_valid = 1'b0;
`ifdef BHT_GHR_EN
      check("hist pred_idx", {26'd0, pred_idx}, {26'd0, 6'b010110});
`else
      check("hist pred_idx", {26'd0, pred_idx}, {26'd0, 6'b010000});
`endif
      check("hist pred_take", {31'd0, pred_take}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_bht.md
# if_bht

Branch history table (BHT) that produces the `take` prediction for conditional branches at fetch and retrains from the execute-stage branch check. It holds 2^`IDX_W` two-bit saturating counters. After reset it clears the table with an init sweep state machine, then serves one prediction and one update per cycle. It also keeps branch and mispredict statistics. It sits between the IF stage (PC, predecode) and the EX-stage branch check (`take`, `predict_fail`).

## Interface
- `XLEN`, 32: address width.
- `IDX_W`, 6: table index width; 64 entries.
- `CNT_W`, 32: width of the statistics counters.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_valid`  in  1  fetch slot holds a conditional branch (from predecode) that needs a prediction.
- `if_pc`  in  XLEN  PC of that branch.
- `pred_take`  out  1  prediction, registered; valid one cycle after `if_valid`.
- `pred_idx`  out  IDX_W  table index used; the pipeline carries it to EX.
- `pred_ready`  out  1  high once the init sweep completes.
- `ex_branch`  in  1  a conditional branch resolves in EX this cycle.
- `ex_idx`  in  IDX_W  `pred_idx` carried with that branch.
- `ex_take`  in  1  prediction carried with that branch.
- `predict_fail`  in  1  EX mispredict flag.
- `br_cnt`  out  CNT_W  resolved branches since reset.
- `miss_cnt`  out  CNT_W  mispredicts since reset.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is counter bit 1.
- Actual outcome: `ex_take ^ predict_fail`.
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- Index without GHR: `if_pc[IDX_W+1:2]`.
- FSM has two states, INIT and RUN.
  - INIT: a sweep pointer writes 01 into one entry per cycle, from 0 to 2^IDX_W-1. After the last write the FSM goes to RUN.
  - RUN: normal predict and update.
- Behaviour during INIT:
  - `pred_ready`=0 and `pred_take`=0.
  - EX updates are dropped and the statistics counters are not incremented.
- RUN is left only on `rst`.
- Statistics counters:
  - `br_cnt` increments on `ex_branch` in RUN.
  - `miss_cnt` increments on `ex_branch & predict_fail` in RUN.
  - Both wrap modulo 2^CNT_W.
- Reset values:
  - State INIT, sweep pointer 0.
  - `pred_take`=0, `pred_idx`=0, `pred_ready`=0.
  - `br_cnt`=`miss_cnt`=0; GHR 0 when compiled in.
  - The table is not reset directly; the sweep initialises it.

## Timing
- Prediction latency is 1 cycle. `pred_take`/`pred_idx` are registered from the cycle `if_valid` is high. They hold their value when `if_valid`=0.
- Update latency is 1 cycle: the counter write lands at the edge ending the `ex_branch` cycle.
- Same-index read and write in one cycle: the read is read-first and returns the pre-update counter. The following read sees the new value.
- No handshake or backpressure: one prediction and one update are accepted every RUN cycle.
- `rst` during INIT or RUN restarts the sweep from entry 0.
  - `pred_ready` rises exactly 2^IDX_W cycles after the first cycle with `rst` deasserted.
- `pred_ready` is registered and rises in the same cycle the FSM enters RUN.

## Configuration
- `BHT_GHR_EN` defined: gshare indexing.
  - An IDX_W-bit global history register shifts in the actual outcome at bit 0 on every RUN `ex_branch`.
  - Index = `if_pc[IDX_W+1:2] ^ ghr`.
  - The GHR is updated non-speculatively, only at resolution. Updates always use `ex_idx` as supplied, so GHR drift between predict and resolve is harmless.
- `BHT_GHR_EN` undefined: no GHR register; the index is PC bits only.

## Structure
- Shared package/defines:
  - counter encodings (`BHT_SNT`, `BHT_WNT`, `BHT_WT`, `BHT_ST`);
  - FSM state constants;
  - `XLEN` from the existing defines.
- One sub-module: `bht_sat_cnt`, a combinational 2-bit saturating next-value function (inc/dec), instanced once on the update path.
- The table is a flop array.

## Test plan
- Init: pulse `rst` for 1 cycle. Required: `pred_ready`=0 for 64 cycles, then 1. Predicting PCs 0x0 through 0xFC returns `pred_take`=0 and the entries hold 01.
- Train taken: three updates at the idx of PC 0x100, each with `ex_take`=0 and `predict_fail`=1. Required: counter goes 01→10→11, and predicting 0x100 gives `pred_take`=1.
- Saturation and hysteresis: five taken updates, then one not-taken. Required: `pred_take`=1 (counter 10). A second not-taken gives `pred_take`=0.
- Collision: `if_valid` and `ex_branch` on the same idx in one cycle, counter 01, actual taken. Required: `pred_take`=0 that cycle; the next prediction gives 1.
- Reset mid-init: assert `rst` at sweep cycle 20. Required: `pred_ready` low for 64 cycles after release. Updates injected during INIT are ignored, and `br_cnt`=0.
- `BHT_GHR_EN`: outcomes T, T, NT resolved. Required: ghr=6'b000110 and, for `if_pc`=0x40, `pred_idx`=6'b010110. `br_cnt`=3 and `miss_cnt` matches the count of `predict_fail` pulses.
